// File: rtl/hdmi_period_scheduler_if.sv
// Raster position, packet-source handshake and period flags between the scheduler
// and its neighbours (raster counters, packet source, TMDS encoders).
interface hdmi_period_scheduler_if;
    logic       enable;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       pkt_valid;
    logic       pkt_ready;
    logic [4:0] pkt_beat;
    logic       in_island;
    logic       in_preamble;
    logic       in_guard;
    logic       guard_island;
    logic [3:0] ctl;

    modport master (
        output enable, hpos, vpos, pkt_valid,
        input  pkt_ready, pkt_beat, in_island, in_preamble, in_guard, guard_island, ctl
    );

    modport slave (
        input  enable, hpos, vpos, pkt_valid,
        output pkt_ready, pkt_beat, in_island, in_preamble, in_guard, guard_island, ctl
    );
endinterface

// File: rtl/hdmi_period_scheduler.sv
// HDMI link-period sequencer: video preamble/guard and data islands, with packet pacing.
// Outputs for pixel position P are registered while hpos==P, so they appear at hpos==P+1.
module hdmi_period_scheduler #(
    parameter int unsigned WIDTH        = 858,
    parameter int unsigned HEIGHT       = 525,
    parameter int unsigned H_IMAGE      = 720,
    parameter int unsigned V_IMAGE      = 480,
    parameter int unsigned ISLAND_START = 736,
    parameter int unsigned MAX_PACKETS  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    hdmi_period_scheduler_if.slave  bus
);
    localparam int unsigned PW         = 10;
    localparam int unsigned ISLAND_END = ISLAND_START + 12 + 32 * MAX_PACKETS;
    // Latest position (as the next beat 0) that still leaves room for a packet and its trail.
    localparam int unsigned ROOM_LAST  = WIDTH - 10 - 34;

    if (MAX_PACKETS < 1 || MAX_PACKETS > 18) begin : g_bad_max_packets
        $error("hdmi_period_scheduler: MAX_PACKETS must be 1..18");
    end
    if (ISLAND_START < H_IMAGE) begin : g_bad_island_start
        $error("hdmi_period_scheduler: ISLAND_START must not overlap the active image");
    end
    if (ISLAND_END > WIDTH - 10) begin : g_bad_island_len
        $error("hdmi_period_scheduler: island overruns the video preamble");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_LEAD,
        S_DATA,
        S_TRAIL
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [4:0] beat_q, beat_d;
    logic [4:0] sent_q, sent_d;

    logic       pkt_ready_q, pkt_ready_d;
    logic [4:0] pkt_beat_q, pkt_beat_d;
    logic       in_island_q, in_island_d;
    logic       in_preamble_q, in_preamble_d;
    logic       in_guard_q, in_guard_d;
    logic       guard_island_q, guard_island_d;
    logic [3:0] ctl_q, ctl_d;

    logic next_line_image_c;
    logic vid_pre_c;
    logic vid_guard_c;
    logic room_c;

    // Video preamble/guard depend only on the raster position and the line type.
    always_comb begin
        next_line_image_c = (bus.vpos < PW'(V_IMAGE - 1)) || (bus.vpos == PW'(HEIGHT - 1));
        vid_pre_c   = bus.enable && next_line_image_c &&
                      (bus.hpos >= PW'(WIDTH - 10)) && (bus.hpos <= PW'(WIDTH - 3));
        vid_guard_c = bus.enable && next_line_image_c && (bus.hpos >= PW'(WIDTH - 2));
        room_c      = (bus.hpos <= PW'(ROOM_LAST));
    end

    // Island sequencing; counters step once per pixel clock.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        sent_d  = sent_q;
        case (state_q)
            S_IDLE: begin
                cnt_d  = 3'd0;
                beat_d = 5'd0;
                sent_d = 5'd0;
                if (bus.enable && bus.pkt_valid && (bus.hpos == PW'(ISLAND_START))) begin
                    state_d = S_PRE;
                end
            end
            S_PRE: begin
                if (cnt_q == 3'd7) begin
                    state_d = S_LEAD;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_LEAD: begin
                if (cnt_q == 3'd1) begin
                    state_d = S_DATA;
                    cnt_d   = 3'd0;
                    beat_d  = 5'd0;
                    sent_d  = 5'd1;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_DATA: begin
                if (beat_q == 5'd31) begin
                    beat_d = 5'd0;
                    if (bus.pkt_valid && bus.enable && (sent_q < 5'(MAX_PACKETS)) && room_c) begin
                        sent_d = sent_q + 5'd1;
                    end else begin
                        state_d = S_TRAIL;
                    end
                end else begin
                    beat_d = beat_q + 5'd1;
                end
            end
            S_TRAIL: begin
                if (cnt_q == 3'd1) begin
                    state_d = S_IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode of the period being entered; island and video periods never coincide.
    always_comb begin
        pkt_ready_d    = (state_d == S_DATA) && (beat_d == 5'd0);
        pkt_beat_d     = (state_d == S_DATA) ? beat_d : 5'd0;
        in_island_d    = (state_d == S_DATA);
        in_preamble_d  = (state_d == S_PRE) || vid_pre_c;
        guard_island_d = (state_d == S_LEAD) || (state_d == S_TRAIL);
        in_guard_d     = guard_island_d || vid_guard_c;
        ctl_d          = 4'b0000;
        if (state_d == S_PRE) begin
            ctl_d = 4'b0101;
        end else if (vid_pre_c) begin
            ctl_d = 4'b0001;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= 3'd0;
            beat_q         <= 5'd0;
            sent_q         <= 5'd0;
            pkt_ready_q    <= 1'b0;
            pkt_beat_q     <= 5'd0;
            in_island_q    <= 1'b0;
            in_preamble_q  <= 1'b0;
            in_guard_q     <= 1'b0;
            guard_island_q <= 1'b0;
            ctl_q          <= 4'b0000;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            beat_q         <= beat_d;
            sent_q         <= sent_d;
            pkt_ready_q    <= pkt_ready_d;
            pkt_beat_q     <= pkt_beat_d;
            in_island_q    <= in_island_d;
            in_preamble_q  <= in_preamble_d;
            in_guard_q     <= in_guard_d;
            guard_island_q <= guard_island_d;
            ctl_q          <= ctl_d;
        end
    end

    assign bus.pkt_ready    = pkt_ready_q;
    assign bus.pkt_beat     = pkt_beat_q;
    assign bus.in_island    = in_island_q;
    assign bus.in_preamble  = in_preamble_q;
    assign bus.in_guard     = in_guard_q;
    assign bus.guard_island = guard_island_q;
    assign bus.ctl          = ctl_q;
endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Scoreboard bench: a per-line reference model predicts every output clock; a monitor
// pops one prediction per clock and compares against the registered outputs.
module tb_hdmi_period_scheduler;
    localparam int WIDTH        = 858;
    localparam int HEIGHT       = 525;
    localparam int V_IMAGE      = 480;
    localparam int ISLAND_START = 736;
    localparam int MAX_PACKETS  = 2;

    typedef struct {
        int          p;
        int          v;
        logic [13:0] e;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    bit   stim_done = 1'b0;

    exp_t        exp_q[$];
    logic [13:0] exp_line [WIDTH];
    logic [13:0] act_vec;

    hdmi_period_scheduler_if bus();

    hdmi_period_scheduler #(.MAX_PACKETS(MAX_PACKETS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign act_vec = {bus.pkt_ready, bus.pkt_beat, bus.in_island, bus.in_preamble,
                      bus.in_guard, bus.guard_island, bus.ctl};

    function automatic logic [13:0] pack(input logic rdy, input logic [4:0] beat, input logic isl,
                                         input logic pre, input logic grd, input logic gi,
                                         input logic [3:0] c);
        return {rdy, beat, isl, pre, grd, gi, c};
    endfunction

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: enable(P) = P<en_until, pkt_valid(P) = P<val_until within this line.
    task automatic build_line(input int v, input int en_until, input int val_until, input int rst_at);
        int n;
        int b0;
        int dec;
        bit more;
        for (int p = 0; p < WIDTH; p++) exp_line[p] = '0;
        if ((v < V_IMAGE - 1) || (v == HEIGHT - 1)) begin
            for (int p = WIDTH - 10; p < WIDTH; p++) begin
                if (p < en_until) begin
                    if (p <= WIDTH - 3) exp_line[p] = pack(1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001);
                    else                exp_line[p] = pack(1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
                end
            end
        end
        if (ISLAND_START < en_until && ISLAND_START < val_until) begin
            for (int k = 0; k < 8; k++)
                exp_line[ISLAND_START + k] = pack(1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0101);
            for (int k = 8; k < 10; k++)
                exp_line[ISLAND_START + k] = pack(1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000);
            b0   = ISLAND_START + 10;
            n    = 1;
            more = 1'b1;
            while (more) begin
                dec = b0 + 32 * n;
                if (dec < en_until && dec < val_until && n < MAX_PACKETS && (dec - 1) + 35 <= WIDTH - 10)
                    n++;
                else
                    more = 1'b0;
            end
            for (int k = 0; k < 32 * n; k++)
                exp_line[b0 + k] = pack((k % 32) == 0, 5'(k % 32), 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
            for (int k = 0; k < 2; k++)
                exp_line[b0 + 32 * n + k] = pack(1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000);
        end
        if (rst_at >= 0) begin
            for (int p = rst_at; p < WIDTH - 10; p++) exp_line[p] = '0;
            exp_line[rst_at] = '0;
        end
    endtask

    task automatic run_line(input int v, input int en_until, input int val_until, input int rst_at);
        exp_t it;
        build_line(v, en_until, val_until, rst_at);
        for (int p = 0; p < WIDTH; p++) begin
            @(negedge clk);
            bus.hpos      = 10'(p);
            bus.vpos      = 10'(v);
            bus.enable    = (p < en_until);
            bus.pkt_valid = (p < val_until);
            reset         = (p == rst_at);
            it.p = p;
            it.v = v;
            it.e = exp_line[p];
            exp_q.push_back(it);
            if (p == rst_at) begin
                #1;
                check("async_reset_immediate", act_vec, 14'h0);
            end
        end
    endtask

    // Monitor: every clock presents the period for the position driven one clock earlier.
    initial begin
        exp_t it;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() != 0) begin
                it = exp_q.pop_front();
                check($sformatf("line%0d_pos%0d", it.v, it.p), act_vec, it.e);
            end
        end
    end

    initial begin
        int v;
        int en_u;
        int val_u;
        reset         = 1'b1;
        bus.enable    = 1'b0;
        bus.pkt_valid = 1'b0;
        bus.hpos      = 10'd0;
        bus.vpos      = 10'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", act_vec, 14'h0);
        @(negedge clk);
        reset = 1'b0;

        run_line(10, WIDTH, 747, -1);          // single packet, video preamble
        run_line(11, WIDTH, WIDTH, -1);        // two back-to-back packets
        run_line(479, WIDTH, 0, -1);           // last image line: no video preamble, no island
        run_line(12, 0, WIDTH, -1);            // DVI mode: nothing
        run_line(13, 750, WIDTH, -1);          // enable drops mid-packet
        run_line(14, WIDTH, WIDTH, 760);       // reset mid-island
        run_line(15, WIDTH, WIDTH, -1);        // island resumes on the next line
        run_line(HEIGHT - 1, WIDTH, 0, -1);    // last vblank line precedes image
        run_line(V_IMAGE - 2, WIDTH, 0, -1);
        run_line(200, WIDTH, 740, -1);         // valid drops during preamble: packet still runs

        for (int i = 0; i < 20; i++) begin
            v = int'($urandom_range(0, HEIGHT - 1));
            case ($urandom_range(0, 3))
                0, 1:    en_u = WIDTH;
                2:       en_u = 0;
                default: en_u = int'($urandom_range(730, 860));
            endcase
            case ($urandom_range(0, 3))
                0:       val_u = WIDTH;
                1:       val_u = 747;
                2:       val_u = int'($urandom_range(700, 820));
                default: val_u = int'($urandom_range(736, 858));
            endcase
            run_line(v, en_u, val_u, -1);
        end

        repeat (4) @(posedge clk);
        #3;
        stim_done = 1'b1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #2000000;
        if (!stim_done) begin
            errors++;
            $display("FAIL timeout actual=running expected=done");
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $fatal(1, "timeout");
        end
    end
endmodule
